// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core front end: nop encoding, default reset PC,
// fetch FSM encodings and the fetch-buffer entry layout.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buf.sv
// Two-entry fetch buffer holding {PC+4, instruction}; supports same-cycle push+pop
// and a flush that overrides both.
module if_fetch_buf
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);

  fetch_entry_t r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_pop;

  assign w_pop   = i_pop && (r_count != 2'd0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(i_push) - 2'(w_pop);
    end
  end

endmodule

// File: rtl/if_fetch.sv
// MIPS instruction-fetch stage: PC register, imem req/ready handshake, 2-deep fetch
// buffer and redirect handling. Optional counters enabled by `define IF_PERF_CNT_EN.
module if_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_if,
  output logic [31:0] Instruction_if,
  output logic        if_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  if (BUF_DEPTH != 2) begin : g_bad_depth
    $error("if_fetch: BUF_DEPTH must be 2");
  end

  logic [1:0]   r_state;
  logic [1:0]   w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_addr;
  logic [31:0]  w_pc_next;
  logic [31:0]  w_redirect_tgt;
  logic         w_xfer;
  logic         w_push;
  logic         w_pop;
  logic         w_issue_ok;
  logic         w_load_addr;
  logic [1:0]   w_count;
  logic [1:0]   w_count_next;
  fetch_entry_t w_head;

  if_fetch_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_data  ('{pc_plus4: r_pc + 32'd4, instr: imem_rdata}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign w_redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req       = (r_state != S_IDLE);
  assign imem_addr      = r_addr;
  assign w_xfer         = imem_req & imem_ready;
  assign w_push         = w_xfer & (r_state == S_WAIT) & ~redirect;
  assign if_valid       = (w_count != 2'd0);
  assign w_pop          = if_valid & ~stall & ~redirect;
  assign w_count_next   = redirect ? 2'd0 : (w_count + 2'(w_push) - 2'(w_pop));
  assign w_issue_ok     = (w_count_next < 2'd2);

  assign PC_if          = if_valid ? w_head.pc_plus4 : '0;
  assign Instruction_if = if_valid ? w_head.instr : NOP_INSTR;

  always_comb begin
    w_pc_next = r_pc;
    if (redirect)    w_pc_next = w_redirect_tgt;
    else if (w_push) w_pc_next = r_pc + 32'd4;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_issue_ok) w_state_next = S_WAIT;
      S_WAIT: begin
        if (w_xfer)        w_state_next = w_issue_ok ? S_WAIT : S_IDLE;
        else if (redirect) w_state_next = S_DROP;
      end
      S_DROP: if (w_xfer) w_state_next = S_WAIT;
      default: w_state_next = S_IDLE;
    endcase
  end

  // The request address is latched only when a new request starts, so it stays
  // on the old target in S_DROP while pc_q already follows the redirect.
  assign w_load_addr = (w_state_next == S_WAIT) && ((r_state == S_IDLE) || w_xfer);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_load_addr) r_addr <= w_pc_next;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (w_push)               perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
      if (!if_valid && !stall)  perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: table of per-cycle inputs/expected outputs plus a
// reset-during-wait sequence. Memory returns the bitwise inverse of the address.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PC_if;
  logic [31:0] Instruction_if;
  logic        if_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign imem_rdata = ~imem_addr;

  if_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .PC_if          (PC_if),
    .Instruction_if (Instruction_if),
    .if_valid       (if_valid)
  );

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(logic s, logic r, logic [31:0] rpc, logic rdy,
                              logic req, logic [31:0] addr, logic v, logic [31:0] pc);
    vec_t t;
    t.stall = s; t.redir = r; t.rpc = rpc; t.ready = rdy;
    t.req = req; t.addr = addr; t.valid = v; t.pc = pc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //               stall redir rpc           rdy  req addr          valid pc
    vecs[0]  = mk(0, 0, 32'h0,         1,   0, 32'h0,         0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0,         1,   1, 32'h0,         0, 32'h0);
    vecs[2]  = mk(0, 0, 32'h0,         1,   1, 32'h4,         1, 32'h4);
    vecs[3]  = mk(0, 0, 32'h0,         1,   1, 32'h8,         1, 32'h8);
    vecs[4]  = mk(0, 0, 32'h0,         1,   1, 32'hC,         1, 32'hC);
    vecs[5]  = mk(1, 0, 32'h0,         1,   1, 32'h10,        1, 32'h10);
    vecs[6]  = mk(1, 0, 32'h0,         1,   0, 32'h0,         1, 32'h10);
    vecs[7]  = mk(1, 0, 32'h0,         1,   0, 32'h0,         1, 32'h10);
    vecs[8]  = mk(1, 0, 32'h0,         1,   0, 32'h0,         1, 32'h10);
    vecs[9]  = mk(0, 0, 32'h0,         1,   0, 32'h0,         1, 32'h10);
    vecs[10] = mk(0, 0, 32'h0,         1,   1, 32'h14,        1, 32'h14);
    vecs[11] = mk(0, 0, 32'h0,         0,   1, 32'h18,        1, 32'h18);
    vecs[12] = mk(0, 0, 32'h0,         0,   1, 32'h18,        0, 32'h0);
    vecs[13] = mk(0, 0, 32'h0,         0,   1, 32'h18,        0, 32'h0);
    vecs[14] = mk(0, 0, 32'h0,         1,   1, 32'h18,        0, 32'h0);
    vecs[15] = mk(0, 0, 32'h0,         1,   1, 32'h1C,        1, 32'h1C);
    vecs[16] = mk(0, 1, 32'h80,        0,   1, 32'h20,        1, 32'h20);
    vecs[17] = mk(0, 1, 32'h103,       0,   1, 32'h20,        0, 32'h0);
    vecs[18] = mk(0, 0, 32'h0,         1,   1, 32'h20,        0, 32'h0);
    vecs[19] = mk(0, 0, 32'h0,         1,   1, 32'h100,       0, 32'h0);
    vecs[20] = mk(1, 0, 32'h0,         1,   1, 32'h104,       1, 32'h104);
    vecs[21] = mk(1, 1, 32'h200,       1,   0, 32'h0,         1, 32'h104);
    vecs[22] = mk(1, 0, 32'h0,         0,   1, 32'h200,       0, 32'h0);
    vecs[23] = mk(0, 0, 32'h0,         1,   1, 32'h200,       0, 32'h0);
    vecs[24] = mk(0, 0, 32'h0,         0,   1, 32'h204,       1, 32'h204);
    vecs[25] = mk(0, 1, 32'hFFFF_FFFC, 0,   1, 32'h204,       0, 32'h0);
    vecs[26] = mk(0, 0, 32'h0,         1,   1, 32'h204,       0, 32'h0);
    vecs[27] = mk(0, 0, 32'h0,         1,   1, 32'hFFFF_FFFC, 0, 32'h0);
    vecs[28] = mk(0, 1, 32'h40,        1,   1, 32'h0,         1, 32'h0);
    vecs[29] = mk(0, 0, 32'h0,         0,   1, 32'h40,        0, 32'h0);

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset imem_req",       {31'b0, imem_req}, 32'h0);
    chk("reset if_valid",       {31'b0, if_valid}, 32'h0);
    chk("reset PC_if",          PC_if,             32'h0);
    chk("reset Instruction_if", Instruction_if,    32'h0);

    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      rst         = 1'b0;
      stall       = vecs[i].stall;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      imem_ready  = vecs[i].ready;
      #1;
      chk($sformatf("c%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
      if (vecs[i].req)
        chk($sformatf("c%0d imem_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("c%0d if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].valid});
      chk($sformatf("c%0d PC_if", i), PC_if, vecs[i].pc);
      chk($sformatf("c%0d Instruction_if", i), Instruction_if,
          vecs[i].valid ? ~(vecs[i].pc - 32'd4) : 32'h0);
    end

    // Reset while a request to 0x40 is outstanding: request drops without a clock.
    @(negedge clk);
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_ready = 1'b0;
    #1;
    chk("prewait imem_req", {31'b0, imem_req}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("async rst imem_req", {31'b0, imem_req}, 32'h0);
    chk("async rst if_valid", {31'b0, if_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    imem_ready = 1'b1;
    #1;
    chk("post rst idle imem_req", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    #1;
    chk("post rst imem_req",  {31'b0, imem_req}, 32'h1);
    chk("post rst imem_addr", imem_addr,          32'h0);
    @(negedge clk);
    #1;
    chk("post rst PC_if",          PC_if,          32'h4);
    chk("post rst Instruction_if", Instruction_if, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
